// File: rtl/alloc_heap_if.sv
// Request/response bundle between the cons-cell engine and the alloc_heap allocator.
interface alloc_heap_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
);
    logic               o_ready;
    logic               i_alloc;
    logic [DATA_SZ-1:0] i_data;
    logic [DATA_SZ-1:0] o_addr;
    logic               i_free;
    logic [DATA_SZ-1:0] i_addr;
    logic               i_wr;
    logic [DATA_SZ-1:0] i_waddr;
    logic [DATA_SZ-1:0] i_wdata;
    logic               i_rd;
    logic [DATA_SZ-1:0] i_raddr;
    logic [DATA_SZ-1:0] o_rdata;
    logic               o_valid;
    logic               o_err;
    logic [2:0]         o_err_code;
    logic [ADDR_SZ:0]   o_free_cnt;
    logic [ADDR_SZ:0]   o_used_cnt;

    modport master (
        input  o_ready, o_addr, o_rdata, o_valid, o_err, o_err_code, o_free_cnt, o_used_cnt,
        output i_alloc, i_data, i_free, i_addr, i_wr, i_waddr, i_wdata, i_rd, i_raddr
    );

    modport slave (
        output o_ready, o_addr, o_rdata, o_valid, o_err, o_err_code, o_free_cnt, o_used_cnt,
        input  i_alloc, i_data, i_free, i_addr, i_wr, i_waddr, i_wdata, i_rd, i_raddr
    );
endinterface

// File: rtl/alloc_heap.sv
// Heap allocator: free-list plus bump pointer over a scrubbed cell memory, with sticky coded errors.
// Define ALLOC_BOUNDS_EN to range-check rd/wr/free addresses against the tag and bump pointer.
module alloc_heap #(
    parameter int                 DATA_SZ  = 16,
    parameter int                 ADDR_SZ  = 8,
    parameter int                 MEM_MAX  = 1 << ADDR_SZ,
    parameter logic [DATA_SZ-1:0] ADDR_TAG = 'h5000,
    parameter logic [DATA_SZ-1:0] NIL_PTR  = 'h0001,
    parameter logic [DATA_SZ-1:0] UNDEF    = 'h0000
) (
    input logic         i_clk,
    input logic         i_rst,
    alloc_heap_if.slave bus
);
    localparam int CW = ADDR_SZ + 1;
    localparam logic [CW-1:0] MEM_CNT = CW'(MEM_MAX);
    localparam logic [CW-1:0] ONE     = CW'(1);
`ifdef ALLOC_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

    state_t             state, state_nxt;
    logic [DATA_SZ-1:0] mem [MEM_MAX];
    logic [CW-1:0]      scrub, top, free_cnt, used_cnt;
    logic [DATA_SZ-1:0] head, link, addr_q, rdata_q;
    logic               vld_q, err_q, ready;
    logic [2:0]         code_q;

    logic               mem_we, err_det, do_pass, do_pop, do_bump, do_push, rd_go;
    logic [ADDR_SZ-1:0] mem_widx;
    logic [DATA_SZ-1:0] mem_wdata;
    logic [2:0]         err_code_nxt;
    logic               ptr_req, mem_req;

    function automatic logic [ADDR_SZ-1:0] idx(input logic [DATA_SZ-1:0] a);
        return a[ADDR_SZ-1:0];
    endfunction

    // Address is out of bounds if its tag is wrong or it points past the bump pointer.
    function automatic logic oob(input logic [DATA_SZ-1:0] a, input logic [CW-1:0] lim);
        return (a[DATA_SZ-1:ADDR_SZ] != ADDR_TAG[DATA_SZ-1:ADDR_SZ]) ||
               ({1'b0, a[ADDR_SZ-1:0]} >= lim);
    endfunction

    assign link    = mem[idx(head)];
    assign ptr_req = bus.i_alloc | bus.i_free;
    assign mem_req = bus.i_rd | bus.i_wr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (scrub == MEM_CNT - ONE) state_nxt = RUN;
            RUN:     if (err_det) state_nxt = HALT;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        ready = (state == RUN);
    end

    always_comb begin
        mem_we       = 1'b0;
        mem_widx     = '0;
        mem_wdata    = UNDEF;
        err_det      = 1'b0;
        err_code_nxt = 3'd0;
        do_pass      = 1'b0;
        do_pop       = 1'b0;
        do_bump      = 1'b0;
        do_push      = 1'b0;
        rd_go        = 1'b0;
        if (state == INIT) begin
            mem_we   = 1'b1;
            mem_widx = scrub[ADDR_SZ-1:0];
        end else if (state == RUN) begin
            if (ptr_req && mem_req) begin
                err_det      = 1'b1;
                err_code_nxt = 3'd2;
            end else if (bus.i_alloc && bus.i_free) begin
                if (BOUNDS_EN && oob(bus.i_addr, top)) begin
                    err_det      = 1'b1;
                    err_code_nxt = 3'd4;
                end else begin
                    do_pass   = 1'b1;
                    mem_we    = 1'b1;
                    mem_widx  = idx(bus.i_addr);
                    mem_wdata = bus.i_data;
                end
            end else if (bus.i_alloc) begin
                if (head != NIL_PTR) begin
                    do_pop    = 1'b1;
                    mem_we    = 1'b1;
                    mem_widx  = idx(head);
                    mem_wdata = bus.i_data;
                end else if (top < MEM_CNT) begin
                    do_bump   = 1'b1;
                    mem_we    = 1'b1;
                    mem_widx  = top[ADDR_SZ-1:0];
                    mem_wdata = bus.i_data;
                end else begin
                    err_det      = 1'b1;
                    err_code_nxt = 3'd1;
                end
            end else if (bus.i_free) begin
                if (used_cnt == '0) begin
                    err_det      = 1'b1;
                    err_code_nxt = 3'd3;
                end else if (BOUNDS_EN && oob(bus.i_addr, top)) begin
                    err_det      = 1'b1;
                    err_code_nxt = 3'd4;
                end else begin
                    do_push   = 1'b1;
                    mem_we    = 1'b1;
                    mem_widx  = idx(bus.i_addr);
                    mem_wdata = head;
                end
            end else if (mem_req) begin
                if (BOUNDS_EN && ((bus.i_rd && oob(bus.i_raddr, top)) ||
                                  (bus.i_wr && oob(bus.i_waddr, top)))) begin
                    err_det      = 1'b1;
                    err_code_nxt = 3'd4;
                end else begin
                    rd_go     = bus.i_rd;
                    mem_we    = bus.i_wr;
                    mem_widx  = idx(bus.i_waddr);
                    mem_wdata = bus.i_wdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    // Read-before-write on rd+wr falls out of the registered read sampling mem at the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scrub    <= '0;
            top      <= '0;
            head     <= NIL_PTR;
            free_cnt <= '0;
            used_cnt <= '0;
            err_q    <= 1'b0;
            code_q   <= 3'd0;
            vld_q    <= 1'b0;
            addr_q   <= UNDEF;
            rdata_q  <= UNDEF;
        end else begin
            vld_q <= do_pass | do_pop | do_bump | rd_go;
            if (state == INIT) scrub <= scrub + ONE;
            if (err_det) begin
                err_q  <= 1'b1;
                code_q <= err_code_nxt;
            end
            if (do_pass) addr_q <= bus.i_addr;
            if (do_pop) begin
                addr_q   <= head;
                head     <= link;
                free_cnt <= free_cnt - ONE;
                used_cnt <= used_cnt + ONE;
            end
            if (do_bump) begin
                addr_q   <= ADDR_TAG | DATA_SZ'(top[ADDR_SZ-1:0]);
                top      <= top + ONE;
                used_cnt <= used_cnt + ONE;
            end
            if (do_push) begin
                head     <= bus.i_addr;
                free_cnt <= free_cnt + ONE;
                used_cnt <= used_cnt - ONE;
            end
            if (rd_go) rdata_q <= mem[idx(bus.i_raddr)];
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_addr     = addr_q;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_valid    = vld_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = code_q;
    assign bus.o_free_cnt = free_cnt;
    assign bus.o_used_cnt = used_cnt;
endmodule

// File: tb/tb_alloc_heap.sv
// Scoreboard bench for alloc_heap at ADDR_SZ=4 / MEM_MAX=16 with hand-computed responses.
module tb_alloc_heap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [16:0] exp_q [$];   // bit 16: 1 = o_addr response, 0 = o_rdata response

    alloc_heap_if #(.DATA_SZ(16), .ADDR_SZ(4)) bus ();

    alloc_heap #(.DATA_SZ(16), .ADDR_SZ(4), .MEM_MAX(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got addr %h rdata %h expected no response",
                         bus.o_addr, bus.o_rdata);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (e[16] && bus.o_addr !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL o_addr: got %h expected %h", bus.o_addr, e[15:0]);
                end else if (!e[16] && bus.o_rdata !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL o_rdata: got %h expected %h", bus.o_rdata, e[15:0]);
                end
            end
        end
    end

    task automatic idle();
        bus.i_alloc = 0; bus.i_free = 0; bus.i_wr = 0; bus.i_rd = 0;
        bus.i_data = 0; bus.i_addr = 0; bus.i_waddr = 0; bus.i_wdata = 0; bus.i_raddr = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_alloc(input logic [15:0] d, input logic [15:0] ea);
        bus.i_alloc = 1; bus.i_data = d;
        exp_q.push_back({1'b1, ea});
        step();
    endtask

    task automatic do_alloc_err(input logic [15:0] d);
        bus.i_alloc = 1; bus.i_data = d;
        step();
    endtask

    task automatic do_free(input logic [15:0] a);
        bus.i_free = 1; bus.i_addr = a;
        step();
    endtask

    task automatic do_rd(input logic [15:0] a, input logic [15:0] ed);
        bus.i_rd = 1; bus.i_raddr = a;
        exp_q.push_back({1'b0, ed});
        step();
    endtask

    task automatic do_rd_ignored(input logic [15:0] a);
        bus.i_rd = 1; bus.i_raddr = a;
        step();
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [15:0] d);
        bus.i_wr = 1; bus.i_waddr = a; bus.i_wdata = d;
        step();
    endtask

    task automatic counts(input string name, input int f, input int u);
        chk({name, "_free"}, 32'(bus.o_free_cnt), 32'(f));
        chk({name, "_used"}, 32'(bus.o_used_cnt), 32'(u));
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_ready", 32'(bus.o_ready), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        chk("rst_code", 32'(bus.o_err_code), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_addr", 32'(bus.o_addr), 0);
        chk("rst_rdata", 32'(bus.o_rdata), 0);
        counts("rst", 0, 0);
        @(posedge clk); #1;
        rst = 0;
        begin
            int cyc;
            cyc = 0;
            // Requests during scrub must be ignored silently.
            bus.i_alloc = 1; bus.i_data = 16'hDEAD;
            for (int i = 0; i < 40; i++) begin
                if (bus.o_ready) break;
                @(posedge clk); #1;
                cyc++;
            end
            idle();
            chk("init_cycles", 32'(cyc), 16);
            chk("init_err", 32'(bus.o_err), 0);
            counts("init", 0, 0);
        end
    endtask

    initial begin
        idle();
        do_reset();

        do_rd(16'h5007, 16'h0000);
        do_alloc(16'h1111, 16'h5000);
        do_alloc(16'h2222, 16'h5001);
        counts("two_alloc", 0, 2);
        do_rd(16'h5001, 16'h2222);

        do_free(16'h5000);
        counts("free1", 1, 1);
        do_alloc(16'h3333, 16'h5000);
        counts("reuse", 0, 2);
        do_rd(16'h5000, 16'h3333);

        bus.i_alloc = 1; bus.i_free = 1; bus.i_addr = 16'h5001; bus.i_data = 16'h4444;
        exp_q.push_back({1'b1, 16'h5001});
        step();
        counts("pass", 0, 2);
        do_rd(16'h5001, 16'h4444);

        do_wr(16'h5001, 16'hABCD);
        bus.i_rd = 1; bus.i_raddr = 16'h5001; bus.i_wr = 1; bus.i_waddr = 16'h5001;
        bus.i_wdata = 16'h1234;
        exp_q.push_back({1'b0, 16'hABCD});
        step();
        do_rd(16'h5001, 16'h1234);

        do_free(16'h5001);
        do_free(16'h5000);
        counts("free2", 2, 0);
        do_alloc(16'h7777, 16'h5000);
        do_alloc(16'h8888, 16'h5001);
        counts("lifo", 0, 2);
        do_rd(16'h5000, 16'h7777);

`ifndef ALLOC_BOUNDS_EN
        // Untagged address aliases onto cell 1.
        do_wr(16'h0011, 16'h9999);
        do_rd(16'h5001, 16'h9999);
`endif

        do_free(16'h5000);
        do_free(16'h5001);
        do_free(16'h5000);
        chk("underflow_err", 32'(bus.o_err), 1);
        chk("underflow_code", 32'(bus.o_err_code), 3);
        chk("underflow_ready", 32'(bus.o_ready), 0);
        counts("underflow", 2, 0);
        do_rd_ignored(16'h5000);

        do_reset();
        bus.i_alloc = 1; bus.i_data = 16'h5555; bus.i_rd = 1; bus.i_raddr = 16'h5000;
        step();
        chk("conflict_err", 32'(bus.o_err), 1);
        chk("conflict_code", 32'(bus.o_err_code), 2);
        chk("conflict_ready", 32'(bus.o_ready), 0);
        counts("conflict", 0, 0);

`ifdef ALLOC_BOUNDS_EN
        do_reset();
        do_alloc(16'hAAAA, 16'h5000);
        do_alloc(16'hBBBB, 16'h5001);
        do_rd_ignored(16'h500F);
        chk("bounds_err", 32'(bus.o_err), 1);
        chk("bounds_code", 32'(bus.o_err_code), 4);
`endif

        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(16'(i + 16'h0100), 16'h5000 + 16'(i));
        counts("full", 0, 16);
        chk("full_ready", 32'(bus.o_ready), 1);
        do_alloc_err(16'hFFFF);
        chk("oom_err", 32'(bus.o_err), 1);
        chk("oom_code", 32'(bus.o_err_code), 1);
        chk("oom_ready", 32'(bus.o_ready), 0);
        counts("oom", 0, 16);
        do_rd_ignored(16'h5003);

        do_reset();
        do_rd(16'h5003, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
